ysyx_25040129_arbiter: RTL and testbench

Two-master AXI4-Lite arbiter placed in front of the crossbar: shares the single crossbar master port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read and write). It grants one complete transaction at a time and forwards the granted master's channels combinationally. Arbitration is round-robin between IFU and LSU. Within the LSU, a pending write is served before a pending read.

---
 rtl/ysyx_25040129_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_ysyx_25040129_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040129_arbiter.sv
// ysyx_25040129_arbiter
//
// Two-master AXI4-Lite arbiter that shares one crossbar master port between
// the instruction fetch unit (IFU, read-only) and the load/store unit (LSU,
// read and write). One complete transaction is granted at a time and the
// granted master's channels are forwarded combinationally. IFU and LSU are
// served round-robin. Inside the LSU a pending write beats a pending read.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   ifu_ar* / ifu_r*         IFU read address / read data channels
//   lsu_ar* / lsu_r*         LSU read address / read data channels
//   lsu_aw* / lsu_w* / lsu_b* LSU write address / data / response channels
//   araddr ... bready        crossbar-side master channels (outputs)
//   arready ... bvalid       crossbar-side responses (inputs)
//   owner                    registered debug: 00 none, 01 IFU, 10 LSU
module ysyx_25040129_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,

    input  logic [31:0] lsu_araddr,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    input  logic [31:0] lsu_awaddr,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_wdata,
    input  logic [1:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    output logic [1:0]  lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,

    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [1:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,

    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } state_t;

    state_t state, next_state;

    // last == 1 means the LSU was granted most recently, so the IFU wins a tie.
    logic last;

    logic ifu_req, lsu_wr_req, lsu_req;

    // A write only counts once both address and data are offered, so a lone
    // awvalid never wins the port.
    always_comb begin
        ifu_req    = ifu_arvalid;
        lsu_wr_req = lsu_awvalid && lsu_wvalid;
        lsu_req    = lsu_arvalid || lsu_wr_req;
    end

    // Next-state logic: round-robin pick in IDLE, otherwise hold the grant
    // until the final handshake of the granted transaction.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (ifu_req && (!lsu_req || last)) begin
                    next_state = IFU_RD;
                end else if (lsu_req) begin
                    next_state = lsu_wr_req ? LSU_WR : LSU_RD;
                end
            end
            IFU_RD: begin
                if (rvalid && ifu_rready) begin
                    next_state = IDLE;
                end
            end
            LSU_RD: begin
                if (rvalid && lsu_rready) begin
                    next_state = IDLE;
                end
            end
            LSU_WR: begin
                if (bvalid && lsu_bready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State, round-robin pointer and debug owner. The pointer only moves on
    // a fresh grant out of IDLE; owner mirrors the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
            owner <= 2'b00;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state != IDLE) begin
                last <= (next_state != IFU_RD);
            end
            case (next_state)
                IFU_RD:         owner <= 2'b01;
                LSU_RD, LSU_WR: owner <= 2'b10;
                default:        owner <= 2'b00;
            endcase
        end
    end

    // Channel forwarding. Everything defaults to zero so channels not owned
    // by the current state (and every channel in IDLE) stay quiet, and a
    // stray crossbar response in IDLE never reaches a master.
    always_comb begin
        ifu_arready = 1'b0;
        ifu_rdata   = 32'd0;
        ifu_rresp   = 2'b00;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = 32'd0;
        lsu_rresp   = 2'b00;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = 2'b00;
        lsu_bvalid  = 1'b0;
        araddr      = 32'd0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        awaddr      = 32'd0;
        awvalid     = 1'b0;
        wdata       = 32'd0;
        wstrb       = 2'b00;
        wvalid      = 1'b0;
        bready      = 1'b0;
        case (state)
            IFU_RD: begin
                araddr      = ifu_araddr;
                arvalid     = ifu_arvalid;
                ifu_arready = arready;
                ifu_rdata   = rdata;
                ifu_rresp   = rresp;
                ifu_rvalid  = rvalid;
                rready      = ifu_rready;
            end
            LSU_RD: begin
                araddr      = lsu_araddr;
                arvalid     = lsu_arvalid;
                lsu_arready = arready;
                lsu_rdata   = rdata;
                lsu_rresp   = rresp;
                lsu_rvalid  = rvalid;
                rready      = lsu_rready;
            end
            LSU_WR: begin
                awaddr      = lsu_awaddr;
                awvalid     = lsu_awvalid;
                lsu_awready = awready;
                wdata       = lsu_wdata;
                wstrb       = lsu_wstrb;
                wvalid      = lsu_wvalid;
                lsu_wready  = wready;
                lsu_bresp   = bresp;
                lsu_bvalid  = bvalid;
                bready      = lsu_bready;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_25040129_arbiter.sv
// Testbench for ysyx_25040129_arbiter: drives both masters and plays the
// crossbar slave, comparing grants and forwarded channels against values
// computed here from the arbitration rules.
module tb_ysyx_25040129_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid, ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid, ifu_rready;
    logic [31:0] lsu_araddr;
    logic        lsu_arvalid, lsu_arready;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rvalid, lsu_rready;
    logic [31:0] lsu_awaddr;
    logic        lsu_awvalid, lsu_awready;
    logic [31:0] lsu_wdata;
    logic [1:0]  lsu_wstrb;
    logic        lsu_wvalid, lsu_wready;
    logic [1:0]  lsu_bresp;
    logic        lsu_bvalid, lsu_bready;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [1:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [1:0]  owner;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_25040129_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .owner(owner)
    );

    typedef struct {
        logic       ifu_ar;
        logic       lsu_ar;
        logic       lsu_aw;
        logic       lsu_w;
        logic [1:0] exp_owner;
        logic       exp_wr;
    } vec_t;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        ifu_araddr = 0; ifu_arvalid = 0; ifu_rready = 0;
        lsu_araddr = 0; lsu_arvalid = 0; lsu_rready = 0;
        lsu_awaddr = 0; lsu_awvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_wvalid = 0; lsu_bready = 0;
        arready = 0; rdata = 0; rresp = 0; rvalid = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;
    endtask

    task automatic doReset();
        rst = 1'b0;
        clearInputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic applyStimulus(input logic ifu_ar, input logic lsu_ar, input logic lsu_aw, input logic lsu_w,
                                 input logic [31:0] ia, input logic [31:0] la, input logic [31:0] wa,
                                 input logic [31:0] wd, input logic [1:0] ws);
        ifu_arvalid = ifu_ar; ifu_araddr = ia;
        lsu_arvalid = lsu_ar; lsu_araddr = la;
        lsu_awvalid = lsu_aw; lsu_awaddr = wa;
        lsu_wvalid  = lsu_w;  lsu_wdata  = wd; lsu_wstrb = ws;
    endtask

    // Called in an IDLE cycle with requests already applied; runs the whole
    // granted transaction and returns in the following IDLE cycle.
    task automatic completeRound(input logic [1:0] exp_own, input logic exp_wr, input logic [31:0] rd);
        logic [31:0] addr;
        logic [1:0]  resp;
        logic        is_ifu;
        tick();
        checkOutput("owner grant", 64'(owner), 64'(exp_own));
        if (exp_own == 2'b00) return;
        resp   = 2'($urandom_range(0, 3));
        is_ifu = (exp_own == 2'b01);
        if (!exp_wr) begin
            addr = is_ifu ? ifu_araddr : lsu_araddr;
            checkOutput("arvalid fwd", 64'(arvalid), 1);
            checkOutput("araddr fwd", 64'(araddr), 64'(addr));
            checkOutput("awvalid idle rd", 64'(awvalid), 0);
            checkOutput("wvalid idle rd", 64'(wvalid), 0);
            arready = 1'b1;
            #1;
            checkOutput("granted arready", 64'(is_ifu ? ifu_arready : lsu_arready), 1);
            checkOutput("other arready", 64'(is_ifu ? lsu_arready : ifu_arready), 0);
            tick();
            arready = 1'b0; rdata = rd; rresp = resp; rvalid = 1'b1;
            ifu_rready = 1'b1; lsu_rready = 1'b1;
            #1;
            checkOutput("granted rdata", 64'(is_ifu ? ifu_rdata : lsu_rdata), 64'(rd));
            checkOutput("granted rresp", 64'(is_ifu ? ifu_rresp : lsu_rresp), 64'(resp));
            checkOutput("granted rvalid", 64'(is_ifu ? ifu_rvalid : lsu_rvalid), 1);
            checkOutput("other rvalid", 64'(is_ifu ? lsu_rvalid : ifu_rvalid), 0);
            checkOutput("rready fwd", 64'(rready), 1);
            checkOutput("owner hold rd", 64'(owner), 64'(exp_own));
            tick();
            rvalid = 1'b0; rdata = 0; rresp = 0; ifu_rready = 1'b0; lsu_rready = 1'b0;
        end else begin
            checkOutput("awvalid fwd", 64'(awvalid), 1);
            checkOutput("awaddr fwd", 64'(awaddr), 64'(lsu_awaddr));
            checkOutput("wvalid fwd", 64'(wvalid), 1);
            checkOutput("wdata fwd", 64'(wdata), 64'(lsu_wdata));
            checkOutput("wstrb fwd", 64'(wstrb), 64'(lsu_wstrb));
            checkOutput("arvalid idle wr", 64'(arvalid), 0);
            arready = 1'b1; awready = 1'b1; wready = 1'b1;
            #1;
            checkOutput("ifu arready wr", 64'(ifu_arready), 0);
            checkOutput("lsu arready wr", 64'(lsu_arready), 0);
            checkOutput("lsu awready", 64'(lsu_awready), 1);
            checkOutput("lsu wready", 64'(lsu_wready), 1);
            tick();
            arready = 1'b0; awready = 1'b0; wready = 1'b0;
            bvalid = 1'b1; bresp = resp; lsu_bready = 1'b1;
            #1;
            checkOutput("lsu bvalid", 64'(lsu_bvalid), 1);
            checkOutput("lsu bresp", 64'(lsu_bresp), 64'(resp));
            checkOutput("bready fwd", 64'(bready), 1);
            tick();
            bvalid = 1'b0; bresp = 0; lsu_bready = 1'b0;
        end
        #1;
        checkOutput("owner after", 64'(owner), 0);
        checkOutput("arvalid after", 64'(arvalid), 0);
        checkOutput("awvalid after", 64'(awvalid), 0);
    endtask

    // Watchdog so the run always ends even if the schedule stalls.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t vecs[10];
        // Reference model: history of granted masters (0 = IFU, 1 = LSU);
        // reset behaves as if the LSU was served last.
        int history[$];
        logic       r_ifu, r_ar, r_aw, r_w, m_wreq, m_lreq;
        logic [1:0] m_own;
        logic       m_wr;

        // Reset state and stray responses in IDLE
        doReset();
        #1;
        checkOutput("reset owner", 64'(owner), 0);
        arready = 1'b1; rvalid = 1'b1; bvalid = 1'b1; rdata = 32'hFFFF_FFFF;
        ifu_rready = 1'b1; lsu_bready = 1'b1;
        #1;
        checkOutput("idle ifu_arready", 64'(ifu_arready), 0);
        checkOutput("idle ifu_rvalid", 64'(ifu_rvalid), 0);
        checkOutput("idle lsu_rvalid", 64'(lsu_rvalid), 0);
        checkOutput("idle lsu_bvalid", 64'(lsu_bvalid), 0);
        checkOutput("idle ifu_rdata", 64'(ifu_rdata), 0);
        checkOutput("idle rready", 64'(rready), 0);
        clearInputs();
        tick();
        checkOutput("owner stray resp", 64'(owner), 0);

        // IFU single read
        doReset();
        applyStimulus(1, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 0);
        completeRound(2'b01, 1'b0, 32'h1234_5678);

        // IFU and LSU reads held together: IFU, LSU, IFU
        doReset();
        applyStimulus(1, 1, 0, 0, 32'h8000_0004, 32'h9000_0000, 0, 0, 0);
        completeRound(2'b01, 1'b0, 32'h1111_1111);
        completeRound(2'b10, 1'b0, 32'h2222_2222);
        completeRound(2'b01, 1'b0, 32'h3333_3333);

        // LSU write with AW handshaking two cycles before W, IFU waiting
        doReset();
        applyStimulus(0, 0, 1, 1, 0, 0, 32'hA000_03F8, 32'h41, 2'b11);
        tick();
        checkOutput("wr owner", 64'(owner), 2);
        checkOutput("wr awaddr", 64'(awaddr), 64'(32'hA000_03F8));
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0100;
        arready = 1'b1; awready = 1'b1;
        #1;
        checkOutput("wr awready", 64'(lsu_awready), 1);
        checkOutput("wr early wready", 64'(lsu_wready), 0);
        checkOutput("wr ifu_arready 0", 64'(ifu_arready), 0);
        tick();
        lsu_awvalid = 1'b0; awready = 1'b0;
        #1;
        checkOutput("wr awvalid dropped", 64'(awvalid), 0);
        checkOutput("wr wvalid held", 64'(wvalid), 1);
        checkOutput("wr ifu_arready 1", 64'(ifu_arready), 0);
        tick();
        wready = 1'b1;
        #1;
        checkOutput("wr late wready", 64'(lsu_wready), 1);
        checkOutput("wr wdata", 64'(wdata), 64'h41);
        checkOutput("wr ifu_arready 2", 64'(ifu_arready), 0);
        tick();
        wready = 1'b0; lsu_wvalid = 1'b0; bvalid = 1'b1; bresp = 2'b00; lsu_bready = 1'b1;
        #1;
        checkOutput("wr bvalid", 64'(lsu_bvalid), 1);
        checkOutput("wr bresp", 64'(lsu_bresp), 0);
        checkOutput("wr ifu_arready 3", 64'(ifu_arready), 0);
        checkOutput("wr owner hold", 64'(owner), 2);
        tick();
        bvalid = 1'b0; lsu_bready = 1'b0; arready = 1'b0;
        #1;
        checkOutput("wr owner done", 64'(owner), 0);
        completeRound(2'b01, 1'b0, 32'hCAFE_F00D);

        // LSU read and write together: write first, then the read
        doReset();
        applyStimulus(0, 1, 1, 1, 0, 32'h0000_3000, 32'h0000_4000, 32'hDEAD_BEEF, 2'b01);
        completeRound(2'b10, 1'b1, 32'h0);
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        completeRound(2'b10, 1'b0, 32'h7777_0000);

        // Reset two cycles into an LSU read
        doReset();
        applyStimulus(0, 1, 0, 0, 0, 32'h0000_5000, 0, 0, 0);
        tick();
        checkOutput("rst-mid owner grant", 64'(owner), 2);
        tick();
        tick();
        rst = 1'b0; arready = 1'b1;
        tick();
        checkOutput("rst-mid owner", 64'(owner), 0);
        checkOutput("rst-mid arvalid", 64'(arvalid), 0);
        checkOutput("rst-mid awvalid", 64'(awvalid), 0);
        checkOutput("rst-mid wvalid", 64'(wvalid), 0);
        checkOutput("rst-mid lsu_arready", 64'(lsu_arready), 0);
        rst = 1'b1; lsu_arvalid = 1'b0; arready = 1'b0;
        tick();

        // rvalid held with rready low for four cycles
        doReset();
        applyStimulus(1, 0, 0, 0, 32'h8000_0200, 0, 0, 0, 0);
        tick();
        arready = 1'b1;
        tick();
        arready = 1'b0; ifu_arvalid = 1'b0;
        rvalid = 1'b1; rdata = 32'h0000_55AA; ifu_rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("stall owner", 64'(owner), 1);
            checkOutput("stall rvalid", 64'(ifu_rvalid), 1);
            tick();
        end
        ifu_rready = 1'b1;
        tick();
        checkOutput("stall done owner", 64'(owner), 0);
        rvalid = 1'b0; ifu_rready = 1'b0;

        // Table-driven chain from reset; expectations follow the round-robin rules
        vecs[0] = '{1, 1, 0, 0, 2'b01, 0};
        vecs[1] = '{1, 1, 0, 0, 2'b10, 0};
        vecs[2] = '{0, 0, 1, 0, 2'b00, 0};
        vecs[3] = '{1, 0, 1, 1, 2'b01, 0};
        vecs[4] = '{1, 1, 1, 1, 2'b10, 1};
        vecs[5] = '{0, 1, 0, 0, 2'b10, 0};
        vecs[6] = '{1, 0, 0, 0, 2'b01, 0};
        vecs[7] = '{1, 0, 1, 0, 2'b01, 0};
        vecs[8] = '{0, 0, 0, 1, 2'b00, 0};
        vecs[9] = '{0, 1, 1, 1, 2'b10, 1};
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].ifu_ar, vecs[i].lsu_ar, vecs[i].lsu_aw, vecs[i].lsu_w,
                          $urandom, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)));
            completeRound(vecs[i].exp_owner, vecs[i].exp_wr, $urandom);
        end

        // Randomized rounds checked against the history-based model
        doReset();
        history.delete();
        history.push_back(1);
        for (int i = 0; i < 300; i++) begin
            r_ifu = 1'($urandom_range(0, 1));
            r_ar  = 1'($urandom_range(0, 1));
            r_aw  = 1'($urandom_range(0, 1));
            r_w   = 1'($urandom_range(0, 1));
            applyStimulus(r_ifu, r_ar, r_aw, r_w, $urandom, $urandom, $urandom, $urandom,
                          2'($urandom_range(0, 3)));
            m_wreq = r_aw && r_w;
            m_lreq = r_ar || m_wreq;
            m_wr   = 1'b0;
            if (r_ifu && (!m_lreq || history[$] == 1)) begin
                m_own = 2'b01;
                history.push_back(0);
            end else if (m_lreq) begin
                m_own = 2'b10;
                m_wr  = m_wreq;
                history.push_back(1);
            end else begin
                m_own = 2'b00;
            end
            completeRound(m_own, m_wr, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
